// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and select encodings for the pipeline muxes.
package cpu_pkg;

  localparam int unsigned WORD_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_TRAP   = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  // Number of 4-input groups needed to cover n inputs.
  function automatic int unsigned ceil_div4(input int unsigned n);
    return (n + 3) / 4;
  endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Combinational N:1 word select; unmatched select yields zero and a range flag.
module mux_nto1_comb
  import cpu_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned NUM_INPUTS = 4,
  localparam int unsigned SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [SEL_W-1:0]                sel,
  input  logic [NUM_INPUTS*WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0]            word_c,
  output logic                            range_err_c
);

  always_comb begin
    word_c      = '0;
    range_err_c = 1'b1;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (sel == SEL_W'(i)) begin
        word_c      = data_in[i*WORD_SIZE +: WORD_SIZE];
        range_err_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Registered N:1 word mux for pipeline boundaries with valid, stall, flush
// and out-of-range select tracking; optional 2-stage group pre-select.
module mux_nto1_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned LATENCY    = 1,
  localparam int unsigned SEL_W     = $clog2(NUM_INPUTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [SEL_W-1:0]                sel,
  input  logic [NUM_INPUTS*WORD_SIZE-1:0] data_in,
  input  logic                            stall,
  input  logic                            flush,
  output logic                            out_valid,
  output logic [WORD_SIZE-1:0]            out,
  output logic                            sel_err
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_n
    $error("mux_nto1_pipe: NUM_INPUTS must be in 2..16");
  end
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_lat
    $error("mux_nto1_pipe: LATENCY must be 1 or 2");
  end

  logic                 out_valid_q;
  logic [WORD_SIZE-1:0] out_q;
  logic                 sel_err_q;

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign sel_err   = sel_err_q;

  if (LATENCY == 1) begin : g_lat1
    logic [WORD_SIZE-1:0] word_c;
    logic                 err_c;

    mux_nto1_comb #(
      .WORD_SIZE (WORD_SIZE),
      .NUM_INPUTS(NUM_INPUTS)
    ) u_mux (
      .sel        (sel),
      .data_in    (data_in),
      .word_c     (word_c),
      .range_err_c(err_c)
    );

    // Priority: reset, flush, stall, load.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_q       <= '0;
        sel_err_q   <= 1'b0;
      end else if (flush) begin
        out_valid_q <= 1'b0;
        sel_err_q   <= 1'b0;
      end else if (!stall) begin
        out_valid_q <= in_valid;
        if (in_valid) begin
          out_q     <= word_c;
          sel_err_q <= err_c;
        end else begin
          sel_err_q <= 1'b0;
        end
      end
    end

  end else begin : g_lat2
    localparam int unsigned G     = ceil_div4(NUM_INPUTS);
    localparam int unsigned PAD_W = G * 4 * WORD_SIZE;
    localparam int unsigned UP_W  = (SEL_W > 2) ? SEL_W - 2 : 1;

    logic [PAD_W-1:0]       padded_c;
    logic [1:0]             lo_sel_c;
    logic [UP_W-1:0]        up_sel_c;
    logic [WORD_SIZE-1:0]   grp_c [G];
    logic [G-1:0]           grp_err_c;
    logic                   range_c;

    logic                   v1_q;
    logic [WORD_SIZE-1:0]   grp_q [G];
    logic [UP_W-1:0]        up_q;
    logic                   err1_q;

    logic [G*WORD_SIZE-1:0] fin_flat_c;
    logic [WORD_SIZE-1:0]   fin_word_c;
    logic                   fin_err_c;

    // Missing inputs of the last group read as zero.
    assign padded_c = PAD_W'(data_in);
    assign lo_sel_c = 2'(sel);
    assign up_sel_c = UP_W'(sel >> 2);
    assign range_c  = (32'(sel) >= NUM_INPUTS) | (|grp_err_c);

    for (genvar g = 0; g < int'(G); g++) begin : g_grp
      mux_nto1_comb #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_INPUTS(4)
      ) u_grp (
        .sel        (lo_sel_c),
        .data_in    (padded_c[g*4*WORD_SIZE +: 4*WORD_SIZE]),
        .word_c     (grp_c[g]),
        .range_err_c(grp_err_c[g])
      );
    end

    always_comb begin
      fin_flat_c = '0;
      for (int g = 0; g < int'(G); g++) begin
        fin_flat_c[g*WORD_SIZE +: WORD_SIZE] = grp_q[g];
      end
    end

    mux_nto1_comb #(
      .WORD_SIZE (WORD_SIZE),
      .NUM_INPUTS(G)
    ) u_fin (
      .sel        (up_q),
      .data_in    (fin_flat_c),
      .word_c     (fin_word_c),
      .range_err_c(fin_err_c)
    );

    // Both stages share one priority chain so stall/flush act on them together.
    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q        <= 1'b0;
        up_q        <= '0;
        err1_q      <= 1'b0;
        for (int g = 0; g < int'(G); g++) grp_q[g] <= '0;
        out_valid_q <= 1'b0;
        out_q       <= '0;
        sel_err_q   <= 1'b0;
      end else if (flush) begin
        v1_q        <= 1'b0;
        err1_q      <= 1'b0;
        out_valid_q <= 1'b0;
        sel_err_q   <= 1'b0;
      end else if (!stall) begin
        v1_q <= in_valid;
        if (in_valid) begin
          for (int g = 0; g < int'(G); g++) grp_q[g] <= grp_c[g];
          up_q   <= up_sel_c;
          err1_q <= range_c;
        end else begin
          err1_q <= 1'b0;
        end
        out_valid_q <= v1_q;
        if (v1_q) begin
          out_q     <= (err1_q || fin_err_c) ? '0 : fin_word_c;
          sel_err_q <= err1_q | fin_err_c;
        end else begin
          sel_err_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised N:1 word multiplexer with a registered output, for pipeline-stage operand and writeback selection: forwarding, PC source and result select.
- Provides valid tracking, stall (hold), flush (kill) and out-of-range select detection.
- Optional 2-stage split for wide N, to keep the mux tree off the critical path.
- Sits at a pipeline boundary, driven by hazard/control logic.

Parameters:
- WORD_SIZE, 32, data word width in bits.
- NUM_INPUTS, 8, number of data inputs; legal range 2..16.
- LATENCY, 1, register stages: 1 (single output register) or 2 (group-of-4 pre-select register, then final select register).
- SEL_W, $clog2(NUM_INPUTS), derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  current sel/data_in are a real transaction.
- sel  input  SEL_W  input index select.
- data_in  input  NUM_INPUTS*WORD_SIZE  flattened inputs; input i = data_in[i*WORD_SIZE +: WORD_SIZE].
- stall  input  1  hold all stages unchanged.
- flush  input  1  invalidate all stages.
- out_valid  output  1  out/sel_err carry a valid result.
- out  output  WORD_SIZE  selected word.
- sel_err  output  1  registered result came from sel >= NUM_INPUTS.

Behaviour:
- Reset (rst=1 at edge): all stage valid bits = 0, all data registers = 0, all sel_err registers = 0. Outputs: out_valid=0, out=0, sel_err=0. rst has priority over flush, stall and in_valid. A transaction in flight at reset is discarded.
- Priority at each edge: rst > flush > stall > normal load.
- flush=1: every stage valid bit cleared in the same edge, including while stall=1. Data registers keep their previous value. sel_err cleared.
- stall=1 (no flush): every stage register holds; in_valid/sel/data_in are ignored. No stage advances independently; no bubble collapse.
- Normal load, LATENCY=1:
  - valid_q <= in_valid.
  - If in_valid=1: out_q <= selected word (or 0 if sel out of range); sel_err_q <= (sel >= NUM_INPUTS).
  - If in_valid=0: out_q holds its last value and sel_err_q <= 0.
  - Latency: 1 cycle from input edge to output.
- Normal load, LATENCY=2:
  - Stage 1 registers G=ceil(NUM_INPUTS/4) group words; group g selects among inputs 4g..4g+3 by sel[1:0]. Missing inputs read as 0.
  - Stage 1 also registers sel[SEL_W-1:2] (0 when SEL_W<=2), the range error bit and valid.
  - Stage 2 selects a group word by the registered upper select bits; same load/hold rules as LATENCY=1.
  - Latency: 2 cycles. Throughput 1 per cycle when not stalled.
- Out-of-range select (only when NUM_INPUTS is not a power of 2): out=0, sel_err=1, out_valid=1. The transaction is not dropped.
- out and sel_err are driven directly from registers; no combinational input-to-output path.
- Illegal parameters (NUM_INPUTS<2 or >16, LATENCY not 1/2): elaboration-time $error.

Decomposition:
- Shared package (cpu_pkg): WORD_SIZE default constant; mux select encodings for the forwarding/PC-source/writeback users (e.g. FWD_NONE=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3).
- One natural sub-module: mux_nto1_comb (parametrised WORD_SIZE/NUM_INPUTS combinational select plus range flag), instantiated once for LATENCY=1, and G+1 times for LATENCY=2.

Test Plan:
- Reset: N=8, L=1. rst=1 for 2 cycles with in_valid=1, sel=3, input3=0xDEADBEEF -> out_valid=0, out=0, sel_err=0 throughout. First valid out appears 1 cycle after rst deasserts.
- Sweep: N=8, L=1. input i = 0x1000+i; sel=0..7 back-to-back with in_valid=1 -> out = 0x1000..0x1007 on consecutive cycles, 1-cycle latency, out_valid=1 each cycle.
- Out of range: N=5, L=1. sel=6, in_valid=1 -> next cycle out=0, sel_err=1, out_valid=1. Following cycle with in_valid=0 -> out_valid=0, sel_err=0, out holds 0.
- Stall hold: N=8, L=2. Issue sel=2 then sel=7 (inputs 0xA2, 0xA7); stall=1 for 3 cycles after the second issue -> out stays 0xA2 with out_valid=1 during the stall. 0xA7 appears 1 cycle after stall drops. Inputs changed during the stall are ignored.
- Flush over stall: N=8, L=2. Two transactions in flight; assert flush=1 and stall=1 together -> next edge out_valid=0 and stage-1 valid=0. After release, no stale result emerges; the next issue (sel=1, 0xA1) emerges 2 cycles later.
- Odd width: N=16, L=2, WORD_SIZE=64. input i = {32'hFFFF_0000, i}; random sel with in_valid toggled randomly, no stall -> scoreboard matches a 2-cycle-delayed model; sel_err is never set.
